// File: rtl/in_pkt_fifo.sv
// USB full-speed IN FIFO: the application pushes bytes, the SIE sources them in packets of at
// most IN_MAXPACKETSIZE bytes, and storage is only released once the host has ACKed the packet.
module in_pkt_fifo #(
    parameter int DEPTH            = 16,
    parameter int IN_MAXPACKETSIZE = 8,
    localparam int AW              = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clk_gate_i,
    input  logic [7:0]    app_in_data_i,
    input  logic          app_in_valid_i,
    output logic          app_in_ready_o,
    output logic [7:0]    in_data_o,
    output logic          in_valid_o,
    input  logic          in_req_i,
    input  logic          in_ready_i,
    input  logic          in_data_ack_i,
    output logic          in_empty_o,
    output logic          in_full_o,
    output logic [AW:0]   in_level_o
);

    localparam int CW = $clog2(IN_MAXPACKETSIZE + 1);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(IN_MAXPACKETSIZE);

    // Handshakes: an app byte transfers on a clock where app_in_valid_i and app_in_ready_o are
    // both high; an SIE byte is consumed on a clock where clk_gate_i, in_ready_i and in_valid_o
    // are all high and neither in_req_i nor in_data_ack_i is asserted.

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   ack_ptr_q, ack_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   snap_ptr_q, snap_ptr_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          app_ready_q, app_ready_d;
    logic [AW:0]   level_d;
    logic          wr_en;
    logic          sie_ev;

    assign in_valid_o     = (rd_ptr_q != snap_ptr_q) && (pkt_cnt_q != CNT_MAX);
    assign in_data_o      = mem_q[rd_ptr_q[AW-1:0]];
    assign in_level_o     = wr_ptr_q - ack_ptr_q;
    assign in_empty_o     = (wr_ptr_q == ack_ptr_q);
    assign in_full_o      = (in_level_o == DEPTH_L);
    assign app_in_ready_o = app_ready_q;

    assign wr_en  = app_in_valid_i & app_ready_q;
    assign sie_ev = clk_gate_i & in_ready_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        ack_ptr_d  = ack_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        snap_ptr_d = snap_ptr_q;
        pkt_cnt_d  = pkt_cnt_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        // A new token rewinds to the last ACKed byte, so a lost ACK resends the same data;
        // the snapshot keeps bytes written after the token out of this packet.
        if (sie_ev) begin
            if (in_req_i) begin
                rd_ptr_d   = ack_ptr_q;
                snap_ptr_d = wr_ptr_q;
                pkt_cnt_d  = '0;
            end else if (in_data_ack_i) begin
                ack_ptr_d = rd_ptr_q;
            end else if (in_valid_o) begin
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                pkt_cnt_d = pkt_cnt_q + CNT_ONE;
            end
        end

        // Ready looks at next-cycle occupancy so a filling write drops it with no lag.
        level_d     = wr_ptr_d - ack_ptr_d;
        app_ready_d = (level_d < DEPTH_L);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            ack_ptr_q   <= '0;
            rd_ptr_q    <= '0;
            snap_ptr_q  <= '0;
            pkt_cnt_q   <= '0;
            app_ready_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            ack_ptr_q   <= ack_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            snap_ptr_q  <= snap_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            app_ready_q <= app_ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= app_in_data_i;
        end
    end

endmodule

// File: tb/tb_in_pkt_fifo.sv
// Bench for in_pkt_fifo: table of packet-level operations with expected status, a byte
// scoreboard for packet contents, and hand sequences for reset, simultaneous events and gating.
module tb_in_pkt_fifo;

    localparam int DEPTH = 16;
    localparam int MPS   = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          clk_gate_i;
    logic [7:0]    app_in_data_i;
    logic          app_in_valid_i;
    logic          app_in_ready_o;
    logic [7:0]    in_data_o;
    logic          in_valid_o;
    logic          in_req_i;
    logic          in_ready_i;
    logic          in_data_ack_i;
    logic          in_empty_o;
    logic          in_full_o;
    logic [AW:0]   in_level_o;

    in_pkt_fifo #(.DEPTH(DEPTH), .IN_MAXPACKETSIZE(MPS)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clk_gate_i     (clk_gate_i),
        .app_in_data_i  (app_in_data_i),
        .app_in_valid_i (app_in_valid_i),
        .app_in_ready_o (app_in_ready_o),
        .in_data_o      (in_data_o),
        .in_valid_o     (in_valid_o),
        .in_req_i       (in_req_i),
        .in_ready_i     (in_ready_i),
        .in_data_ack_i  (in_data_ack_i),
        .in_empty_o     (in_empty_o),
        .in_full_o      (in_full_o),
        .in_level_o     (in_level_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] held_q[$];   // bytes between ack pointer and write pointer
    logic [7:0] exp_q[$];    // bytes still expected in the current packet
    int delivered = 0;       // bytes sourced since the last ACK / token

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic sie_pulse(input logic req, input logic ack);
        in_req_i      = req;
        in_data_ack_i = ack;
        in_ready_i    = 1'b1;
        clk_gate_i    = 1'b1;
        cycle();
        in_req_i      = 1'b0;
        in_data_ack_i = 1'b0;
        in_ready_i    = 1'b0;
        clk_gate_i    = 1'b0;
    endtask

    task automatic wr_bytes(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            int budget = 0;
            app_in_valid_i = 1'b1;
            app_in_data_i  = start + 8'(i);
            while (app_in_ready_o !== 1'b1 && budget < 32) begin
                cycle();
                budget++;
            end
            if (app_in_ready_o !== 1'b1) begin
                chk("wr_ready_timeout", 32'(app_in_ready_o), 32'd1);
                break;
            end
            cycle();
            held_q.push_back(app_in_data_i);
        end
        app_in_valid_i = 1'b0;
    endtask

    task automatic wr_drop();
        chk("drop_ready", 32'(app_in_ready_o), 32'd0);
        app_in_valid_i = 1'b1;
        app_in_data_i  = 8'hEE;
        cycle();
        app_in_valid_i = 1'b0;
    endtask

    task automatic do_req();
        int n;
        sie_pulse(1'b1, 1'b0);
        exp_q.delete();
        n = (held_q.size() < MPS) ? held_q.size() : MPS;
        for (int i = 0; i < n; i++) exp_q.push_back(held_q[i]);
        delivered = 0;
    endtask

    task automatic do_ack();
        sie_pulse(1'b0, 1'b1);
        repeat (delivered) void'(held_q.pop_front());
        delivered = 0;
    endtask

    task automatic do_read(input int n);
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_low", 32'(in_valid_o), 32'd0);
            end else begin
                chk("rd_valid", 32'(in_valid_o), 32'd1);
                chk("rd_data", 32'(in_data_o), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                delivered++;
            end
            sie_pulse(1'b0, 1'b0);
        end
        if (exp_q.size() == 0) chk("rd_valid_end", 32'(in_valid_o), 32'd0);
    endtask

    task automatic chk_status(input string tag, input int lvl, input logic e, input logic f,
                              input logic r);
        chk({tag, "_level"}, 32'(in_level_o), 32'(lvl));
        chk({tag, "_empty"}, 32'(in_empty_o), 32'(e));
        chk({tag, "_full"},  32'(in_full_o),  32'(f));
        chk({tag, "_ready"}, 32'(app_in_ready_o), 32'(r));
    endtask

    // ---------------- vector table ----------------
    typedef enum int {OP_WR, OP_WX, OP_REQ, OP_RD, OP_ACK} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] arg;
        int         n;
        int         exp_level;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_ready;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input op_e op, input logic [7:0] arg, input int n, input int lvl,
                                input logic e, input logic f, input logic r);
        vec_t v;
        v.op = op; v.arg = arg; v.n = n; v.exp_level = lvl;
        v.exp_empty = e; v.exp_full = f; v.exp_ready = r;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        rst_i = 1'b1; clk_gate_i = 1'b0; app_in_data_i = 8'h00; app_in_valid_i = 1'b0;
        in_req_i = 1'b0; in_ready_i = 1'b0; in_data_ack_i = 1'b0;

        // multi-packet
        vecs.push_back(mk(OP_WR,  8'h00, 12, 12, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_REQ, 8'h00, 0,  12, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_RD,  8'h00, 8,  12, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_ACK, 8'h00, 0,  4,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_REQ, 8'h00, 0,  4,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_RD,  8'h00, 4,  4,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_ACK, 8'h00, 0,  0,  1'b1, 1'b0, 1'b1));
        // retry without ACK
        vecs.push_back(mk(OP_WR,  8'hA0, 3,  3,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_REQ, 8'h00, 0,  3,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_RD,  8'h00, 3,  3,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_REQ, 8'h00, 0,  3,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_RD,  8'h00, 3,  3,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_ACK, 8'h00, 0,  0,  1'b1, 1'b0, 1'b1));
        // full, drop, release, refill across the pointer wrap
        vecs.push_back(mk(OP_WR,  8'h10, 16, 16, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(OP_WX,  8'h00, 0,  16, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(OP_REQ, 8'h00, 0,  16, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(OP_RD,  8'h00, 8,  16, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(OP_ACK, 8'h00, 0,  8,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_WR,  8'h30, 8,  16, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(OP_REQ, 8'h00, 0,  16, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(OP_RD,  8'h00, 8,  16, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(OP_ACK, 8'h00, 0,  8,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_REQ, 8'h00, 0,  8,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_RD,  8'h00, 8,  8,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(OP_ACK, 8'h00, 0,  0,  1'b1, 1'b0, 1'b1));

        // power-on reset
        cycle(); cycle();
        chk_status("por", 0, 1'b1, 1'b0, 1'b0);
        chk("por_valid", 32'(in_valid_o), 32'd0);
        rst_i = 1'b0;
        cycle();
        chk("por_ready_after", 32'(app_in_ready_o), 32'd1);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR:   wr_bytes(vecs[i].arg, vecs[i].n);
                OP_WX:   wr_drop();
                OP_REQ:  do_req();
                OP_RD:   do_read(vecs[i].n);
                default: do_ack();
            endcase
            chk_status($sformatf("v%0d", i), vecs[i].exp_level, vecs[i].exp_empty,
                       vecs[i].exp_full, vecs[i].exp_ready);
        end

        // app write on the same clock as the ACK
        wr_bytes(8'h50, 4);
        do_req();
        do_read(4);
        app_in_valid_i = 1'b1;
        app_in_data_i  = 8'h60;
        sie_pulse(1'b0, 1'b1);
        app_in_valid_i = 1'b0;
        repeat (delivered) void'(held_q.pop_front());
        delivered = 0;
        held_q.push_back(8'h60);
        chk("sim_level", 32'(in_level_o), 32'd1);
        chk("sim_not_in_pkt", 32'(in_valid_o), 32'd0);
        do_req();
        do_read(1);
        do_ack();
        chk("sim_empty", 32'(in_empty_o), 32'd1);

        // in_ready_i without the gate strobe must not move anything
        wr_bytes(8'h70, 2);
        do_req();
        for (int k = 0; k < 3; k++) begin
            in_ready_i    = 1'b1;
            clk_gate_i    = 1'b0;
            in_data_ack_i = (k == 1);
            in_req_i      = (k == 2);
            cycle();
            chk($sformatf("nogate%0d_valid", k), 32'(in_valid_o), 32'd1);
            chk($sformatf("nogate%0d_data", k), 32'(in_data_o), 32'h70);
            chk($sformatf("nogate%0d_level", k), 32'(in_level_o), 32'd2);
        end
        in_ready_i = 1'b0; in_data_ack_i = 1'b0; in_req_i = 1'b0;
        do_read(2);
        do_ack();
        chk("nogate_empty", 32'(in_empty_o), 32'd1);

        // reset in the middle of a packet with unacknowledged bytes
        wr_bytes(8'h80, 5);
        do_req();
        do_read(2);
        app_in_valid_i = 1'b1;
        app_in_data_i  = 8'h99;
        rst_i = 1'b1;
        cycle();
        chk("rst_ready_low", 32'(app_in_ready_o), 32'd0);
        cycle();
        chk_status("rst", 0, 1'b1, 1'b0, 1'b0);
        chk("rst_valid", 32'(in_valid_o), 32'd0);
        rst_i = 1'b0;
        app_in_valid_i = 1'b0;
        held_q.delete(); exp_q.delete(); delivered = 0;
        cycle();
        chk("rst_ready_after", 32'(app_in_ready_o), 32'd1);
        wr_bytes(8'h90, 2);
        do_req();
        do_read(2);
        do_ack();
        chk_status("post_rst", 0, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
